// File: rtl/fa_bist.sv
// fa_bist: built-in self-test sequencer for a single-bit full adder.
// Walks all eight {a,b,cin} input combinations, waits SETTLE_CYC cycles per
// vector, checks {cout,sum} against the arithmetic sum and reports a pass
// flag, a mismatch count and the index of the first failing vector.
// Optional build macro: FA_BIST_STOP_ON_FAIL_EN -- end the run at the first
// mismatch instead of walking all eight vectors.
module fa_bist #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       fa_a,
    output logic       fa_b,
    output logic       fa_cin,
    input  logic       fa_sum,
    input  logic       fa_cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] first_fail_vec
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_APPLY = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [2:0] r_vec;
    logic [3:0] r_wait_cnt;
    logic [3:0] r_err_cnt;
    logic [2:0] r_first_fail;
    logic       r_pass;

    logic [1:0] w_expect;
    logic       w_mismatch;
    logic       w_settled;
    logic       w_stop;
    logic [3:0] w_err_next;

    // Reference result for the vector currently driven to the adder.
    assign w_expect   = {1'b0, r_vec[2]} + {1'b0, r_vec[1]} + {1'b0, r_vec[0]};
    assign w_mismatch = ({fa_cout, fa_sum} != w_expect);
    assign w_settled  = (r_wait_cnt == 4'(SETTLE_CYC - 1));
    assign w_err_next = (w_mismatch && (r_err_cnt != 4'd8)) ? r_err_cnt + 4'd1 : r_err_cnt;

`ifdef FA_BIST_STOP_ON_FAIL_EN
    assign w_stop = w_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: if (start) w_next = ST_APPLY;
            ST_APPLY:         w_next = ST_WAIT;
            ST_WAIT:          if (w_settled) w_next = ST_CHECK;
            ST_CHECK:         w_next = (w_stop || (r_vec == 3'd7)) ? ST_DONE : ST_APPLY;
            default:          w_next = ST_IDLE;
        endcase
    end

    // Vector index, settle counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec        <= '0;
            r_wait_cnt   <= '0;
            r_err_cnt    <= '0;
            r_first_fail <= '0;
            r_pass       <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_vec        <= '0;
                        r_err_cnt    <= '0;
                        r_first_fail <= '0;
                        r_pass       <= 1'b0;
                    end
                end
                ST_APPLY: r_wait_cnt <= '0;
                ST_WAIT:  r_wait_cnt <= r_wait_cnt + 4'd1;
                ST_CHECK: begin
                    r_err_cnt <= w_err_next;
                    if (w_mismatch && (r_err_cnt == 4'd0)) begin
                        r_first_fail <= r_vec;
                    end
                    // pass is only ever raised on the edge that enters DONE.
                    if (w_next == ST_DONE) begin
                        r_pass <= (w_err_next == 4'd0);
                    end else begin
                        r_vec <= r_vec + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fa_a           = r_vec[2];
    assign fa_b           = r_vec[1];
    assign fa_cin         = r_vec[0];
    assign busy           = (r_state == ST_APPLY) || (r_state == ST_WAIT) || (r_state == ST_CHECK);
    assign done           = (r_state == ST_DONE);
    assign pass           = r_pass;
    assign err_cnt        = r_err_cnt;
    assign first_fail_vec = r_first_fail;

endmodule

// File: tb/tb_fa_bist.sv
// tb_fa_bist: directed bench for fa_bist with a behavioural adder under test.
// Honours FA_BIST_STOP_ON_FAIL_EN for the failing-adder expectations.
module tb_fa_bist;

`ifdef FA_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       start3;
    logic       cout_stuck0;

    logic       fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic       busy, done, pass;
    logic [3:0] err_cnt;
    logic [2:0] first_fail_vec;

    logic       fa_a3, fa_b3, fa_cin3, fa_sum3, fa_cout3;
    logic       busy3, done3, pass3;
    logic [3:0] err_cnt3;
    logic [2:0] first_fail_vec3;

    int unsigned n_checks;
    int unsigned n_fail;

    // Adder for the SETTLE_CYC=1 instance, with selectable cout stuck-at-0.
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = cout_stuck0 ? 1'b0 : ((fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin));

    // Adder for the SETTLE_CYC=3 instance, with sum inverted.
    assign fa_sum3  = ~(fa_a3 ^ fa_b3 ^ fa_cin3);
    assign fa_cout3 = (fa_a3 & fa_b3) | (fa_a3 & fa_cin3) | (fa_b3 & fa_cin3);

    fa_bist #(.SETTLE_CYC(1)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .fa_a           (fa_a),
        .fa_b           (fa_b),
        .fa_cin         (fa_cin),
        .fa_sum         (fa_sum),
        .fa_cout        (fa_cout),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_fail_vec (first_fail_vec)
    );

    fa_bist #(.SETTLE_CYC(3)) u_dut3 (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start3),
        .fa_a           (fa_a3),
        .fa_b           (fa_b3),
        .fa_cin         (fa_cin3),
        .fa_sum         (fa_sum3),
        .fa_cout        (fa_cout3),
        .busy           (busy3),
        .done           (done3),
        .pass           (pass3),
        .err_cnt        (err_cnt3),
        .first_fail_vec (first_fail_vec3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Start a run on u_dut; optionally re-pulse start at edge glitch_at while busy.
    task automatic run1(input string tag, input int glitch_at, output int cycles);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_start_done"}, done, 0);
        check({tag, "_start_err"}, err_cnt, 0);
        check({tag, "_start_pass"}, pass, 0);
        check({tag, "_start_busy"}, busy, 1);
        cycles = 0;
        while (!done && cycles < 100) begin
            if ((cycles % 3 == 0) && (cycles < 24) && (cycles < 9 || cycles == 21))
                check({tag, "_vec"}, {fa_a, fa_b, fa_cin}, cycles / 3);
            @(posedge clk);
            #1;
            cycles++;
            start = (cycles == glitch_at);
        end
        start = 1'b0;
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        int cyc;
        int n;
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        start3      = 1'b0;
        cout_stuck0 = 1'b0;

        // Reset state of both instances.
        repeat (2) @(negedge clk);
        check("rst_outs", {fa_a, fa_b, fa_cin, busy, done, pass, err_cnt, first_fail_vec}, 0);
        check("rst_outs3", {fa_a3, fa_b3, fa_cin3, busy3, done3, pass3, err_cnt3, first_fail_vec3}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Good adder.
        run1("good", 0, cyc);
        check("good_cycles", cyc, 24);
        check("good_done", done, 1);
        check("good_pass", pass, 1);
        check("good_err", err_cnt, 0);
        check("good_ffv", first_fail_vec, 0);

        // cout stuck at 0: vectors 3,5,6,7 fail. Starting from DONE also checks restart clears.
        cout_stuck0 = 1'b1;
        run1("stuck", 0, cyc);
        check("stuck_cycles", cyc, STOP ? 12 : 24);
        check("stuck_err", err_cnt, STOP ? 1 : 4);
        check("stuck_ffv", first_fail_vec, 3);
        check("stuck_pass", pass, 0);
        check("stuck_done", done, 1);
        // DONE holds its results.
        repeat (3) @(negedge clk);
        check("stuck_hold", {done, pass, err_cnt, first_fail_vec}, STOP ? {1'b1, 1'b0, 4'd1, 3'd3} : {1'b1, 1'b0, 4'd4, 3'd3});

        // start pulsed while busy is ignored.
        cout_stuck0 = 1'b0;
        run1("glitch", 5, cyc);
        check("glitch_cycles", cyc, 24);
        check("glitch_pass", pass, 1);
        check("glitch_err", err_cnt, 0);

        // Reset mid-run at vector 4.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while ({fa_a, fa_b, fa_cin} != 3'd4 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("midrun_vec", {fa_a, fa_b, fa_cin}, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_outs", {fa_a, fa_b, fa_cin, busy, done, pass, err_cnt, first_fail_vec}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {busy, done}, 0);
        run1("after_rst", 0, cyc);
        check("after_rst_cycles", cyc, 24);
        check("after_rst_pass", pass, 1);

        // SETTLE_CYC=3 instance with inverted sum: every vector fails.
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        n = 0;
        while (!done3 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("inv_cycles", n, STOP ? 5 : 40);
        check("inv_err", err_cnt3, STOP ? 1 : 8);
        check("inv_ffv", first_fail_vec3, 0);
        check("inv_pass", pass3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
